// File: rtl/return_address_stack_pkg.sv
// Shared constants for the return address stack and the PC-source encodings
// used by pcModule.
package return_address_stack_pkg;

    localparam int RAS_DEPTH  = 8;
    localparam int RAS_ADDR_W = 16;

    // PC source select; pcRET means "take the return address this cycle".
    typedef enum logic [1:0] {
        pcDefault = 2'd0,
        pcRET     = 2'd1,
        pcImm     = 2'd2,
        pcSgnImm  = 2'd3
    } pc_src_e;

endpackage

// File: rtl/return_address_stack_if.sv
// Bus between the control/PC logic (master) and the return address stack (slave).
interface return_address_stack_if
    import return_address_stack_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH,
    parameter int WIDTH = RAS_ADDR_W
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic             sig_call;
    pc_src_e          sig_pc_src;
    logic [WIDTH-1:0] PC;
    logic [WIDTH-1:0] ReturnAddress;
    logic [CNT_W-1:0] count;
    logic             empty;
    logic             full;
    logic             overflow;
    logic             underflow;

    modport master (
        output sig_call, sig_pc_src, PC,
        input  ReturnAddress, count, empty, full, overflow, underflow
    );

    modport slave (
        input  sig_call, sig_pc_src, PC,
        output ReturnAddress, count, empty, full, overflow, underflow
    );

endinterface

// File: rtl/return_address_stack_ras_storage.sv
// DEPTH x WIDTH register array with one synchronous write port and one
// asynchronous read port. Contents are deliberately not reset.
module ras_storage #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                     clock,
    input  logic                     i_we,
    input  logic [$clog2(DEPTH)-1:0] i_waddr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic [$clog2(DEPTH)-1:0] i_raddr,
    output logic [WIDTH-1:0]         o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Single write port, committed on the rising edge.
    always_ff @(posedge clock) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/return_address_stack.sv
// Return address stack: circular buffer of return addresses with a top
// pointer, entry count and sticky overflow/underflow flags.
// Optional feature macro: RAS_OVERFLOW_WRAP_EN -- when defined, a push into a
// full stack overwrites the oldest entry instead of being dropped.
module return_address_stack
    import return_address_stack_pkg::*;
#(
    parameter int DEPTH = RAS_DEPTH,
    parameter int WIDTH = RAS_ADDR_W
) (
    input  logic                   clock,
    input  logic                   reset,
    return_address_stack_if.slave  bus
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PTR_W-1:0] r_top;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic             r_underflow;

    logic             sig_call;
    logic             sig_ret;
    logic             w_empty;
    logic             w_full;
    logic             w_we;
    logic             w_we_gated;
    logic [PTR_W-1:0] w_waddr;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_rdata;
    logic [PTR_W-1:0] w_top_next;
    logic [CNT_W-1:0] w_count_next;
    logic             w_set_ovf;
    logic             w_set_unf;

    assign sig_call = bus.sig_call;
    assign sig_ret  = (bus.sig_pc_src == pcRET);
    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == FULL_CNT);
    // PC+1 wraps naturally at 2^WIDTH.
    assign w_wdata  = bus.PC + 1'b1;

    // Decide the write, pointer/count update and error flags for this cycle.
    always_comb begin
        w_we         = 1'b0;
        w_waddr      = r_top + 1'b1;
        w_top_next   = r_top;
        w_count_next = r_count;
        w_set_ovf    = 1'b0;
        w_set_unf    = 1'b0;
        if (sig_call && sig_ret && !w_empty) begin
            w_we    = 1'b1;
            w_waddr = r_top;
        end else if (sig_call) begin
            if (!w_full) begin
                w_we         = 1'b1;
                w_top_next   = r_top + 1'b1;
                w_count_next = r_count + 1'b1;
            end else begin
`ifdef RAS_OVERFLOW_WRAP_EN
                w_we       = 1'b1;
                w_top_next = r_top + 1'b1;
`else
                w_set_ovf  = 1'b1;
`endif
            end
        end else if (sig_ret) begin
            if (!w_empty) begin
                w_top_next   = r_top - 1'b1;
                w_count_next = r_count - 1'b1;
            end else begin
                w_set_unf = 1'b1;
            end
        end
    end

    // A write must never land while reset is held, so in-flight pushes are dropped.
    assign w_we_gated = w_we & reset;

    // Pointer, count and sticky flags, all cleared asynchronously by reset.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_top       <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_top       <= w_top_next;
            r_count     <= w_count_next;
            r_overflow  <= r_overflow  | w_set_ovf;
            r_underflow <= r_underflow | w_set_unf;
        end
    end

    ras_storage #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) u_storage (
        .clock   (clock),
        .i_we    (w_we_gated),
        .i_waddr (w_waddr),
        .i_wdata (w_wdata),
        .i_raddr (r_top),
        .o_rdata (w_rdata)
    );

    // Top of stack is read combinationally so pcModule can use it in the RET cycle.
    assign bus.ReturnAddress = w_empty ? '0 : w_rdata;
    assign bus.count         = r_count;
    assign bus.empty         = w_empty;
    assign bus.full          = w_full;
    assign bus.overflow      = r_overflow;
    assign bus.underflow     = r_underflow;

endmodule

// File: tb/tb_return_address_stack.sv
// Self-checking bench for return_address_stack: directed scenarios followed by
// random call/ret traffic, compared against a queue-based stack model.
module tb_return_address_stack;
    import return_address_stack_pkg::*;

    localparam int DEPTH = 8;
    localparam int WIDTH = 16;

    logic clock;
    logic reset;

    int nAsserts;
    int nFails;

    // Reference model: back of the queue is the top of stack.
    logic [WIDTH-1:0] mq[$];
    bit               mOvf;
    bit               mUnf;

    return_address_stack_if #(.DEPTH(DEPTH), .WIDTH(WIDTH)) bus();

    return_address_stack #(
        .DEPTH (DEPTH),
        .WIDTH (WIDTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock, period 10.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nAsserts++;
        assert (obs === exp) else begin
            nFails++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic modelClear();
        mq.delete();
        mOvf = 1'b0;
        mUnf = 1'b0;
    endtask

    task automatic modelStep(input bit call, input bit ret, input logic [WIDTH-1:0] pc);
        logic [WIDTH-1:0] v;
        v = pc + 16'd1;
        if (call && ret && mq.size() > 0) begin
            mq[mq.size()-1] = v;
        end else if (call) begin
            if (mq.size() < DEPTH) begin
                mq.push_back(v);
            end else begin
`ifdef RAS_OVERFLOW_WRAP_EN
                void'(mq.pop_front());
                mq.push_back(v);
`else
                mOvf = 1'b1;
`endif
            end
        end else if (ret) begin
            if (mq.size() > 0) void'(mq.pop_back());
            else mUnf = 1'b1;
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [WIDTH-1:0] expRa;
        expRa = (mq.size() > 0) ? mq[mq.size()-1] : '0;
        checkVal({tag, ".ra"},    32'(bus.ReturnAddress), 32'(expRa));
        checkVal({tag, ".count"}, 32'(bus.count),         32'(mq.size()));
        checkVal({tag, ".empty"}, 32'(bus.empty),         32'(mq.size() == 0));
        checkVal({tag, ".full"},  32'(bus.full),          32'(mq.size() == DEPTH));
        checkVal({tag, ".ovf"},   32'(bus.overflow),      32'(mOvf));
        checkVal({tag, ".unf"},   32'(bus.underflow),     32'(mUnf));
    endtask

    task automatic applyStimulus(input string tag, input bit call, input bit ret, input logic [WIDTH-1:0] pc);
        bus.sig_call   = call;
        bus.sig_pc_src = ret ? pcRET : pcImm;
        bus.PC         = pc;
        @(posedge clock);
        #1;
        modelStep(call, ret, pc);
        checkOutput(tag);
    endtask

    task automatic applyReset(input string tag);
        @(negedge clock);
        reset = 1'b0;
        #1;
        modelClear();
        checkOutput(tag);
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        int r;
        bit c;
        bit t;
        nAsserts       = 0;
        nFails         = 0;
        reset          = 1'b0;
        bus.sig_call   = 1'b0;
        bus.sig_pc_src = pcDefault;
        bus.PC         = '0;
        modelClear();
        $display("[TB] start");

        // Reset then idle
        applyReset("rst");
        applyStimulus("idle", 1'b0, 1'b0, 16'd0);
        checkVal("idleEmpty", 32'(bus.empty), 32'd1);
        checkVal("idleRa", 32'(bus.ReturnAddress), 32'd0);

        // Push 5, push 20, pop, pop
        applyStimulus("push5", 1'b1, 1'b0, 16'd5);
        applyStimulus("push20", 1'b1, 1'b0, 16'd20);
        checkVal("push20Ra", 32'(bus.ReturnAddress), 32'd21);
        checkVal("push20Cnt", 32'(bus.count), 32'd2);
        applyStimulus("pop1", 1'b0, 1'b1, 16'd0);
        checkVal("pop1Ra", 32'(bus.ReturnAddress), 32'd6);
        applyStimulus("pop2", 1'b0, 1'b1, 16'd0);
        checkVal("pop2Ra", 32'(bus.ReturnAddress), 32'd0);
        checkVal("pop2Empty", 32'(bus.empty), 32'd1);

        // Underflow is sticky
        applyStimulus("popEmpty", 1'b0, 1'b1, 16'd0);
        checkVal("unfSet", 32'(bus.underflow), 32'd1);
        for (int i = 0; i < 3; i++) applyStimulus("unfIdle", 1'b0, 1'b0, 16'd0);
        checkVal("unfSticky", 32'(bus.underflow), 32'd1);
        checkVal("unfCnt", 32'(bus.count), 32'd0);

        // Nine pushes into a depth-8 stack
        applyReset("rst2");
        for (int i = 0; i < 9; i++) applyStimulus("fill", 1'b1, 1'b0, 16'(i));
        checkVal("fillCnt", 32'(bus.count), 32'd8);
        checkVal("fillFull", 32'(bus.full), 32'd1);
`ifdef RAS_OVERFLOW_WRAP_EN
        checkVal("wrapRa", 32'(bus.ReturnAddress), 32'd9);
        checkVal("wrapOvf", 32'(bus.overflow), 32'd0);
        for (int i = 0; i < 8; i++) begin
            checkVal("wrapPopRa", 32'(bus.ReturnAddress), 32'(9 - i));
            applyStimulus("wrapPop", 1'b0, 1'b1, 16'd0);
        end
        checkVal("wrapDrained", 32'(bus.empty), 32'd1);
`else
        checkVal("dropRa", 32'(bus.ReturnAddress), 32'd8);
        checkVal("dropOvf", 32'(bus.overflow), 32'd1);
`endif

        // PC wrap and simultaneous call/ret
        applyReset("rst3");
        applyStimulus("pushMax", 1'b1, 1'b0, 16'hFFFF);
        checkVal("pushMaxRa", 32'(bus.ReturnAddress), 32'h0000);
        checkVal("pushMaxCnt", 32'(bus.count), 32'd1);
        applyStimulus("callRet", 1'b1, 1'b1, 16'd40);
        checkVal("callRetRa", 32'(bus.ReturnAddress), 32'd41);
        checkVal("callRetCnt", 32'(bus.count), 32'd1);
        applyStimulus("pop3", 1'b0, 1'b1, 16'd0);
        applyStimulus("callRetEmpty", 1'b1, 1'b1, 16'd77);
        checkVal("callRetEmptyRa", 32'(bus.ReturnAddress), 32'd78);

        // Asynchronous reset mid-cycle with a push in flight
        applyReset("rst4");
        for (int i = 0; i < 3; i++) applyStimulus("pre", 1'b1, 1'b0, 16'(10 * i));
        checkVal("preCnt", 32'(bus.count), 32'd3);
        bus.sig_call   = 1'b1;
        bus.sig_pc_src = pcImm;
        bus.PC         = 16'd500;
        #2;
        reset = 1'b0;
        #1;
        modelClear();
        checkOutput("asyncRst");
        @(posedge clock);
        #1;
        checkOutput("rstHeld");
        #3;
        reset = 1'b1;
        applyStimulus("postRst", 1'b1, 1'b0, 16'd100);
        checkVal("postRstRa", 32'(bus.ReturnAddress), 32'd101);

        // Random traffic against the model
        for (int n = 0; n < 400; n++) begin
            if (n % 100 == 0) applyReset("rndRst");
            r = int'($urandom_range(0, 9));
            c = (r < 5) || (r == 9);
            t = (r >= 5);
            applyStimulus("rnd", c, t, 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
        $finish;
    end

endmodule

// File: doc/return_address_stack.md
RETURN_ADDRESS_STACK -- requirements
Module: return_address_stack

Interface
REQ-001 The block SHALL have parameter DEPTH, default 8, meaning number of stored return addresses (power of two, 2..16).
REQ-002 The block SHALL have parameter WIDTH, default 16, meaning address width (equal to the PC width).
REQ-003 The block SHALL have port clock, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port sig_call, input, 1 bit: CALL in the current cycle; push PC+1.
REQ-006 The block SHALL have port sig_ret, input, 1 bit: RET in the current cycle; pop the top entry.
REQ-007 The block SHALL have port PC, input, WIDTH bits: the address of the current instruction, from pcModule.
REQ-008 The block SHALL have port ReturnAddress, output, WIDTH bits: the top-of-stack value, feeding pcModule's return-address input.
REQ-009 The block SHALL have port count, output, $clog2(DEPTH)+1 bits: the number of valid entries.
REQ-010 The block SHALL have ports empty and full, outputs, 1 bit each: count==0 and count==DEPTH respectively.
REQ-011 The block SHALL have ports overflow and underflow, outputs, 1 bit each: sticky error flags.

Function
REQ-012 ReturnAddress SHALL be the top entry, combinationally read from registered storage; when empty it SHALL be 0.
- pcModule consumes ReturnAddress in the same cycle that sig_ret is asserted.
- Zero extra latency.
REQ-013 For a push (sig_call=1, sig_ret=0, not full), the block SHALL, on the clock edge, write PC+1 (modulo 2^WIDTH) above the top and increment count.
REQ-014 For a pop (sig_ret=1, sig_call=0, not empty), the block SHALL, on the clock edge, decrement count; the new top is visible in the next cycle.
REQ-015 When sig_call and sig_ret are both 1 and the stack is not empty, the block SHALL overwrite the top entry with PC+1 and leave count unchanged.
REQ-016 When sig_call and sig_ret are both 1 and the stack is empty, the block SHALL behave as a plain push.
REQ-017 A pop when empty SHALL leave state unchanged and set underflow.
REQ-018 Push-when-full behaviour SHALL be as given in Configuration.
REQ-019 overflow and underflow SHALL remain set until reset.
REQ-020 Storage SHALL be a circular buffer indexed by a top pointer modulo DEPTH.
- PC+1 = 16'hFFFF+1 SHALL store 16'h0000.

Reset
REQ-021 While reset=0, the block SHALL asynchronously force:
- count=0, top pointer=0, empty=1, full=0;
- overflow=0, underflow=0, ReturnAddress=0.
REQ-022 Storage contents need not be cleared on reset.
REQ-023 A reset asserted mid-operation SHALL discard any in-flight push or pop in that cycle.
REQ-024 The first edge after reset deassertion SHALL operate normally.

Configuration
REQ-025 With macro RAS_OVERFLOW_WRAP_EN defined, a push when full SHALL overwrite the oldest entry, advance the top pointer and keep count=DEPTH, without setting overflow.
REQ-026 Without RAS_OVERFLOW_WRAP_EN, a push when full SHALL be ignored, leaving storage, pointer and count unchanged, and SHALL set overflow.

Structure
REQ-027 The shared constants file SHALL hold RAS_DEPTH (8) and RAS_ADDR_W (16) alongside the existing pcDefault/pcRET/pcImm/pcSgnImm encodings.
REQ-028 The top level SHALL derive sig_ret as (sig_pc_src==pcRET).
REQ-029 One sub-module, ras_storage, SHALL hold the DEPTH x WIDTH register array, with one synchronous write port and one asynchronous read port.
REQ-030 Pointer, count and flag logic SHALL reside in return_address_stack.

Verification
REQ-031 Reset then idle -> empty=1, count=0, ReturnAddress=0, overflow=0, underflow=0.
REQ-032 Push PC=5, then push PC=20 -> ReturnAddress=21, count=2; pop -> next cycle ReturnAddress=6, count=1; pop -> ReturnAddress=0, empty=1.
REQ-033 Pop when empty -> count stays 0, underflow=1 and remains 1 after 3 further idle cycles.
REQ-034 9 pushes with PC=0..8, DEPTH=8 ->
- without macro: count=8, full=1, overflow=1, ReturnAddress=8;
- with macro: count=8, ReturnAddress=9, overflow=0, and 8 pops return 9,8,...,2.
REQ-035 Push PC=16'hFFFF -> ReturnAddress=16'h0000.
- Then sig_call=sig_ret=1 with PC=40 -> ReturnAddress=41, count unchanged at 1.
REQ-036 reset=0 asserted mid-cycle with count=3 -> outputs clear immediately, before the next clock edge.
